rename_free_list: RTL

//  Physical-register free list for the rename stage: supplies up to WIDTH new pregs per cycle for dispatchStruct.rd.

---
 rtl/rename_free_list_pkg.sv | 18 +
 rtl/rename_free_list_chk.sv | 73 +++++++
 rtl/rename_free_list.sv | 99 +++++++++
 3 files changed

// File: rtl/rename_free_list_pkg.sv
// Shared rename-stage types: preg sizing, free-list geometry and the dispatch record.
// Types and constants only; no latency or backpressure.
package rename_free_list_pkg;
   localparam int NUM_PREG = 64;
   localparam int NUM_AREG = 32;
   localparam int PREG_W   = $clog2(NUM_PREG);
   localparam int DEPTH    = NUM_PREG - NUM_AREG;
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = $clog2(DEPTH + 1);

   typedef logic [PREG_W-1:0] preg_t;

   typedef struct packed {
      logic  vld;
      preg_t rd;
      preg_t rd_old;
   } dispatchStruct;
endpackage

// File: rtl/rename_free_list_chk.sv
// Busy map and release filter: drops releases of p0, out-of-range, already-free or duplicated pregs.
// Filter is combinational; busy map and sticky err update at the clock edge; never stalls.
module rename_free_list_chk
   import rename_free_list_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int RET_W = 2
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        alloc_vld,
   input  logic [WIDTH*PREG_W-1:0] alloc_preg,
   input  logic [RET_W-1:0]        rel_valid,
   input  logic [RET_W*PREG_W-1:0] rel_preg,
   output logic [RET_W-1:0]        rel_ok,
   output logic                    err
);
   localparam logic [PREG_W:0]     PREG_LIM = (PREG_W + 1)'(NUM_PREG);
   localparam logic [NUM_PREG-1:0] BUSY_RST = {{DEPTH{1'b0}}, {NUM_AREG{1'b1}}};

   logic [NUM_PREG-1:0] busy_q, busy_d;
   logic                err_q, err_d;
   preg_t               rp [RET_W];
   logic [RET_W-1:0]    bad;

   always_comb begin
      bad = '0;
      for (int j = 0; j < RET_W; j++) begin
         rp[j] = rel_preg[j*PREG_W +: PREG_W];
      end
      for (int j = 0; j < RET_W; j++) begin
         if (rp[j] == '0 || {1'b0, rp[j]} >= PREG_LIM) begin
            bad[j] = 1'b1;
         end else if (!busy_q[rp[j]]) begin
            bad[j] = 1'b1;
         end
         for (int k = 0; k < j; k++) begin
            if (rel_valid[k] && rp[k] == rp[j]) bad[j] = 1'b1;
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      err_d  = err_q;
      rel_ok = '0;
      for (int j = 0; j < RET_W; j++) begin
         if (rel_valid[j]) begin
            if (bad[j]) begin
               err_d = 1'b1;
            end else begin
               rel_ok[j]      = 1'b1;
               busy_d[rp[j]] = 1'b0;
            end
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (alloc_vld[i]) busy_d[alloc_preg[i*PREG_W +: PREG_W]] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= BUSY_RST;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
endmodule

// File: rtl/rename_free_list.sv
// Circular free list of pregs: all-or-nothing alloc of up to WIDTH, release of up to RET_W per cycle.
// Alloc pregs are show-ahead (same cycle); alloc_ready drops below WIDTH free; FREELIST_CHECK_EN adds release checking.
module rename_free_list
   import rename_free_list_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int RET_W = 2
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        alloc_req,
   output logic                    alloc_ready,
   output logic [WIDTH*PREG_W-1:0] alloc_preg,
   input  logic [RET_W-1:0]        rel_valid,
   input  logic [RET_W*PREG_W-1:0] rel_preg,
   output logic [CNT_W-1:0]        free_count,
   output logic                    err
);
   preg_t            entry_q [DEPTH];
   preg_t            entry_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] aoff [WIDTH];
   logic [PTR_W-1:0] roff [RET_W];
   logic [CNT_W-1:0] nalloc, nrel;
   logic [RET_W-1:0] rel_ok;
   logic             fire;

   // Lane compaction: each lane's slot is the number of active lanes below it.
   always_comb begin
      nalloc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         aoff[i] = PTR_W'(nalloc);
         nalloc  = nalloc + CNT_W'(alloc_req[i]);
      end
      nrel = '0;
      for (int j = 0; j < RET_W; j++) begin
         roff[j] = PTR_W'(nrel);
         nrel    = nrel + CNT_W'(rel_ok[j]);
      end
   end

   assign alloc_ready = (count_q >= CNT_W'(WIDTH));
   assign fire        = (|alloc_req) && alloc_ready;
   assign free_count  = count_q;

   always_comb begin
      alloc_preg = '0;
      for (int i = 0; i < WIDTH; i++) begin
         alloc_preg[i*PREG_W +: PREG_W] = entry_q[PTR_W'(head_q + aoff[i])];
      end
   end

   always_comb begin
      entry_d = entry_q;
      for (int j = 0; j < RET_W; j++) begin
         if (rel_ok[j]) entry_d[PTR_W'(tail_q + roff[j])] = rel_preg[j*PREG_W +: PREG_W];
      end
      head_d  = fire ? PTR_W'(head_q + PTR_W'(nalloc)) : head_q;
      tail_d  = PTR_W'(tail_q + PTR_W'(nrel));
      count_d = count_q - (fire ? nalloc : '0) + nrel;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) entry_q[k] <= PREG_W'(NUM_AREG + k);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(DEPTH);
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifdef FREELIST_CHECK_EN
   logic [WIDTH-1:0] alloc_vld;
   assign alloc_vld = alloc_req & {WIDTH{fire}};

   rename_free_list_chk #(
      .WIDTH (WIDTH),
      .RET_W (RET_W)
   ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .alloc_vld  (alloc_vld),
      .alloc_preg (alloc_preg),
      .rel_valid  (rel_valid),
      .rel_preg   (rel_preg),
      .rel_ok     (rel_ok),
      .err        (err)
   );
`else
   assign rel_ok = rel_valid;
   assign err    = 1'b0;
`endif
endmodule
